// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg
// Shared definitions for the data-memory arbiter slice.
//   DMEM_BASE / DMEM_LIMIT : byte window decoded as data memory (8 KiB)
//   port_idx_t             : index of a requesting port (0 = LSU, 1 = boot/debug)
//   dmem_req_t             : one access as presented to the dmem port
//   inRange()              : window check used for write gating and error status
package dmem_arb_pkg;

    localparam logic [15:0] DMEM_BASE  = 16'h2000;
    localparam logic [15:0] DMEM_LIMIT = 16'h3FFF;

    typedef logic port_idx_t;

    typedef struct packed {
        logic [15:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wren;
    } dmem_req_t;

    function automatic logic inRange(input logic [15:0] addr);
        return (addr >= DMEM_BASE) && (addr <= DMEM_LIMIT);
    endfunction

endpackage

// File: rtl/dmem_rr_arb.sv
// dmem_rr_arb
// Round-robin grant between two requesters, with a bounded lock that lets
// port 1 keep the memory for back-to-back bursts.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_valid[1:0]   : request pending per port
//   i_lock         : port 1 asks for consecutive grants
//   o_grant[1:0]   : one-hot grant, combinational
module dmem_rr_arb
    import dmem_arb_pkg::*;
#(
    parameter int LOCK_MAX = 8
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [1:0] i_valid,
    input  logic       i_lock,
    output logic [1:0] o_grant
);

    localparam int CW = $clog2(LOCK_MAX + 1);

    port_idx_t       lastGrant_q, lastGrant_d;
    logic [CW-1:0]   lockCnt_q, lockCnt_d;
    logic            lockHold;
    logic            lockSpent;

    // lockHold keeps port 1 only while the burst budget is not used up;
    // once spent, a waiting port 0 takes the next slot.
    always_comb begin
        lockHold  = (lastGrant_q == 1'b1) && i_lock && (lockCnt_q < CW'(LOCK_MAX));
        lockSpent = (lockCnt_q == CW'(LOCK_MAX));
        o_grant   = 2'b00;
        unique case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11: begin
                if (lockHold)
                    o_grant = 2'b10;
                else if (lockSpent)
                    o_grant = 2'b01;
                else if (lastGrant_q == 1'b1)
                    o_grant = 2'b01;
                else
                    o_grant = 2'b10;
            end
            default: o_grant = 2'b00;
        endcase
    end

    // The lock counter saturates so port 1 can continue alone when port 0
    // is idle; any port-0 grant or a cycle without lock restarts the budget.
    always_comb begin
        lastGrant_d = lastGrant_q;
        lockCnt_d   = lockCnt_q;
        if (o_grant[0]) begin
            lastGrant_d = 1'b0;
            lockCnt_d   = '0;
        end else if (o_grant[1]) begin
            lastGrant_d = 1'b1;
            if (!i_lock)
                lockCnt_d = '0;
            else if (!lockSpent)
                lockCnt_d = lockCnt_q + CW'(1);
        end else if (!i_lock) begin
            lockCnt_d = '0;
        end
    end

    // Reset to lastGrant = 1 so port 0 wins the first contention.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            lastGrant_q <= 1'b1;
            lockCnt_q   <= '0;
        end else begin
            lastGrant_q <= lastGrant_d;
            lockCnt_q   <= lockCnt_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
// Two-port arbiter/sequencer in front of the 8 KiB data memory.
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_pN_valid/addr/wdata/wren     : requester N (0 = LSU, 1 = boot/debug)
//   i_p1_lock                      : port 1 burst lock
//   o_pN_ready                     : request accepted this cycle (combinational)
//   o_pN_rvalid/rdata/err          : registered response, one cycle after accept
//   o_dmem_addr/wdata/wren         : access driven to dmem
//   i_dmem_rdata                   : combinational dmem read data
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int LOCK_MAX = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_p0_valid,
    input  logic [15:0] i_p0_addr,
    input  logic [31:0] i_p0_wdata,
    input  logic [3:0]  i_p0_wren,
    input  logic        i_p1_valid,
    input  logic [15:0] i_p1_addr,
    input  logic [31:0] i_p1_wdata,
    input  logic [3:0]  i_p1_wren,
    input  logic        i_p1_lock,
    output logic        o_p0_ready,
    output logic        o_p0_rvalid,
    output logic [31:0] o_p0_rdata,
    output logic        o_p0_err,
    output logic        o_p1_ready,
    output logic        o_p1_rvalid,
    output logic [31:0] o_p1_rdata,
    output logic        o_p1_err,
    output logic [15:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    output logic [3:0]  o_dmem_wren,
    input  logic [31:0] i_dmem_rdata
);

    logic [1:0]  grant;
    dmem_req_t   selReq;
    logic        selInRange;
    logic [31:0] rspRdata_d;

    logic [1:0]  rvalid_q;
    logic [1:0]  err_q;
    logic [31:0] rdata_q [2];

    dmem_rr_arb #(
        .LOCK_MAX (LOCK_MAX)
    ) u_rr_arb (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_valid ({i_p1_valid, i_p0_valid}),
        .i_lock  (i_p1_lock),
        .o_grant (grant)
    );

    // With no grant the selected request stays all-zero, which also falls
    // outside the window, so dmem sees address 0 and no write enables.
    always_comb begin
        selReq = '0;
        if (grant[0])
            selReq = '{addr: i_p0_addr, wdata: i_p0_wdata, wren: i_p0_wren};
        else if (grant[1])
            selReq = '{addr: i_p1_addr, wdata: i_p1_wdata, wren: i_p1_wren};
        selInRange   = inRange(selReq.addr);
        o_dmem_addr  = selReq.addr;
        o_dmem_wdata = selReq.wdata;
        o_dmem_wren  = selInRange ? selReq.wren : 4'b0000;
        rspRdata_d   = (selInRange && (selReq.wren == 4'b0000)) ? i_dmem_rdata : 32'h0;
    end

    assign o_p0_ready = grant[0];
    assign o_p1_ready = grant[1];

    // Response registers; rdata/err hold between responses, rvalid is a strobe.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rvalid_q <= '0;
            err_q    <= '0;
            for (int p = 0; p < 2; p++)
                rdata_q[p] <= '0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                rvalid_q[p] <= grant[p];
                if (grant[p]) begin
                    rdata_q[p] <= rspRdata_d;
                    err_q[p]   <= !selInRange;
                end
            end
        end
    end

    assign o_p0_rvalid = rvalid_q[0];
    assign o_p0_rdata  = rdata_q[0];
    assign o_p0_err    = err_q[0];
    assign o_p1_rvalid = rvalid_q[1];
    assign o_p1_rdata  = rdata_q[1];
    assign o_p1_err    = err_q[1];

endmodule
